// File: rtl/bf_pkg.sv
// bf_pkg
//  Shared definitions for the BF core and its I/O peripherals.
//  - BF opcode character constants (also used by the core's decoder).
//  - TX state encoding for the stdout UART (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4).
//  - even_parity(): helper for the optional parity bit (BF_UART_PARITY_EN).
package bf_pkg;

   localparam logic [7:0] OP_RIGHT      = 8'h3E;  // '>'
   localparam logic [7:0] OP_LEFT       = 8'h3C;  // '<'
   localparam logic [7:0] OP_INC        = 8'h2B;  // '+'
   localparam logic [7:0] OP_DEC        = 8'h2D;  // '-'
   localparam logic [7:0] OP_OUT        = 8'h2E;  // '.'
   localparam logic [7:0] OP_IN         = 8'h2C;  // ','
   localparam logic [7:0] OP_LOOP_OPEN  = 8'h5B;  // '['
   localparam logic [7:0] OP_LOOP_CLOSE = 8'h5D;  // ']'
   localparam logic [7:0] ZERO          = 8'h00;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      PARITY = 3'd4
   } tx_state_t;

   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/bf_sync_fifo.sv
// bf_sync_fifo
//  Single-clock FIFO with combinational read of the head entry (no output register),
//  so pop_data is valid whenever empty=0. Used for BF stdout, and later for stdin.
// Ports
//  clk        in   clock
//  reset      in   asynchronous active-low reset (pointers and count only)
//  push       in   write push_data; ignored while full
//  push_data  in   WIDTH
//  pop        in   drop the head entry; ignored while empty
//  pop_data   out  WIDTH, head entry
//  full/empty out  status
//  count      out  ADDR_WIDTH+1 bits, number of stored entries
module bf_sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  pop,
   output logic [WIDTH-1:0]      pop_data,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_reg;
   logic [ADDR_WIDTH-1:0] rd_ptr_reg;
   logic [ADDR_WIDTH:0]   count_reg;
   logic                  do_push;
   logic                  do_pop;

   assign full     = (count_reg == CNT_DEPTH);
   assign empty    = (count_reg == '0);
   assign count    = count_reg;
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr_reg];

   // Storage has no reset so it can map onto distributed/block RAM.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Pointers wrap naturally modulo DEPTH; count disambiguates full from empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_ONE;
            2'b01:   count_reg <= count_reg - CNT_ONE;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/bf_stdout_uart.sv
// bf_stdout_uart
//  Consumes the BF core's stdout strobe, buffers bytes in a FIFO and sends them
//  as an async serial frame on tx (8N1; 8E1 when BF_UART_PARITY_EN is defined).
//  cpu_en stalls the core while the FIFO is nearly full.
// Ports
//  clk        in   clock
//  reset      in   asynchronous active-low reset, released synchronously
//  stdout     in   8, byte from core
//  stdout_en  in   output strobe; only its rising edge pushes
//  cpu_en     out  core enable, 0 = stall
//  tx         out  serial line, idle high
//  tx_busy    out  frame in progress or bytes pending
//  overflow   out  sticky, a byte was dropped on a full FIFO
// Configuration
//  BF_UART_PARITY_EN: adds an even-parity bit between the data and stop bits.
module bf_stdout_uart
   import bf_pkg::*;
#(
   parameter int CLKS_PER_BIT    = 104,
   parameter int FIFO_ADDR_WIDTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] stdout,
   input  logic       stdout_en,
   output logic       cpu_en,
   output logic       tx,
   output logic       tx_busy,
   output logic       overflow
);

   localparam int DEPTH  = 2 ** FIFO_ADDR_WIDTH;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0]        BAUD_LAST    = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0]        BAUD_ONE     = BAUD_W'(1);
   localparam logic [FIFO_ADDR_WIDTH:0] CPU_EN_LIMIT = (FIFO_ADDR_WIDTH + 1)'(DEPTH - 1);

   // Reset asserts immediately, deasserts two clocks after reset goes high.
   logic [1:0] rst_sync_reg;
   logic       rst_n_int;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync_reg <= 2'b00;
      else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
   end
   assign rst_n_int = rst_sync_reg[1];

   logic                     stdout_en_q_reg;
   logic                     overflow_reg;
   logic                     cpu_en_reg;
   logic                     tx_reg, tx_next;
   tx_state_t                state_reg, state_next;
   logic [BAUD_W-1:0]        baud_reg, baud_next;
   logic [2:0]               bit_reg, bit_next;
   logic [7:0]               shreg_reg, shreg_next;
`ifdef BF_UART_PARITY_EN
   logic                     parity_reg;
`endif

   logic                     push;
   logic                     pop;
   logic [7:0]               fifo_dout;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [FIFO_ADDR_WIDTH:0] fifo_count;
   logic                     baud_tc;

   // A strobe held high while the core is stalled must only push once.
   assign push    = stdout_en & ~stdout_en_q_reg;
   assign baud_tc = (baud_reg == BAUD_LAST);

   bf_sync_fifo #(
      .WIDTH      (8),
      .ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (rst_n_int),
      .push      (push),
      .push_data (stdout),
      .pop       (pop),
      .pop_data  (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      state_next = state_reg;
      baud_next  = baud_reg;
      bit_next   = bit_reg;
      shreg_next = shreg_reg;
      pop        = 1'b0;
      tx_next    = 1'b1;
      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               shreg_next = fifo_dout;
               baud_next  = '0;
               bit_next   = '0;
               state_next = START;
            end
         end
         START: begin
            tx_next = 1'b0;
            if (baud_tc) begin
               baud_next  = '0;
               state_next = DATA;
            end else begin
               baud_next = baud_reg + BAUD_ONE;
            end
         end
         DATA: begin
            tx_next = shreg_reg[0];
            if (baud_tc) begin
               baud_next  = '0;
               shreg_next = {1'b0, shreg_reg[7:1]};
               if (bit_reg == 3'd7) begin
`ifdef BF_UART_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end else begin
                  bit_next = bit_reg + 3'd1;
               end
            end else begin
               baud_next = baud_reg + BAUD_ONE;
            end
         end
`ifdef BF_UART_PARITY_EN
         PARITY: begin
            tx_next = parity_reg;
            if (baud_tc) begin
               baud_next  = '0;
               state_next = STOP;
            end else begin
               baud_next = baud_reg + BAUD_ONE;
            end
         end
`endif
         STOP: begin
            tx_next = 1'b1;
            if (baud_tc) begin
               baud_next  = '0;
               state_next = IDLE;
            end else begin
               baud_next = baud_reg + BAUD_ONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // tx is registered, so the line lags the FSM state by one clock: a push at
   // edge N pops at N+1 and the start bit appears from N+2.
   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         stdout_en_q_reg <= 1'b0;
         overflow_reg    <= 1'b0;
         cpu_en_reg      <= 1'b1;
         tx_reg          <= 1'b1;
         state_reg       <= IDLE;
         baud_reg        <= '0;
         bit_reg         <= '0;
         shreg_reg       <= '0;
`ifdef BF_UART_PARITY_EN
         parity_reg      <= 1'b0;
`endif
      end else begin
         stdout_en_q_reg <= stdout_en;
         if (push && fifo_full) overflow_reg <= 1'b1;
         // One slot of slack: the core may still emit one more byte after the stall.
         cpu_en_reg      <= (fifo_count < CPU_EN_LIMIT);
         tx_reg          <= tx_next;
         state_reg       <= state_next;
         baud_reg        <= baud_next;
         bit_reg         <= bit_next;
         shreg_reg       <= shreg_next;
`ifdef BF_UART_PARITY_EN
         if (pop) parity_reg <= even_parity(fifo_dout);
`endif
      end
   end

   assign cpu_en   = cpu_en_reg;
   assign tx       = tx_reg;
   assign overflow = overflow_reg;
   assign tx_busy  = (state_reg != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_bf_stdout_uart.sv
// Testbench for bf_stdout_uart with CLKS_PER_BIT=4, FIFO_ADDR_WIDTH=2 (depth 4).
// Stimulus pushes expected frames into a queue; a monitor decodes tx cycle by
// cycle and compares each frame (bit values and exact bit durations).
module tb_bf_stdout_uart;

   localparam int CPB = 4;
`ifdef BF_UART_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] stdout = 8'h00;
   logic       stdout_en = 1'b0;
   logic       cpu_en;
   logic       tx;
   logic       tx_busy;
   logic       overflow;

   int n_checks = 0;
   int n_pass   = 0;

   // Each entry: {expected parity bit, expected byte}
   logic [8:0] exp_q[$];
   bit         mon_en   = 1'b0;
   bit         mon_busy = 1'b0;

   bf_stdout_uart #(
      .CLKS_PER_BIT    (CPB),
      .FIFO_ADDR_WIDTH (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .stdout    (stdout),
      .stdout_en (stdout_en),
      .cpu_en    (cpu_en),
      .tx        (tx),
      .tx_busy   (tx_busy),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input bit ok, input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Called at a negedge: strobe high for one posedge, then one low cycle.
   task automatic send_pulse(input logic [7:0] b, input logic par, input bit expect_frame);
      if (expect_frame) exp_q.push_back({par, b});
      stdout    = b;
      stdout_en = 1'b1;
      @(negedge clk);
      stdout_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !tx_busy && !mon_busy) begin
            done = 1'b1;
            break;
         end
      end
      check(done, name, 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: a low tx at a negedge starts a frame; every cycle of the frame
   // is compared against the expected bit.
   initial begin
      logic [8:0]    e;
      logic [10:0]   f;
      logic [7:0]    got;
      logic          got_par;
      int            errs;
      forever begin
         @(negedge clk);
         if (mon_en && tx === 1'b0) begin
            mon_busy = 1'b1;
            if (exp_q.size() == 0) begin
               check(1'b0, "spurious_frame", 32'(tx), 32'h1);
               // let the unexpected frame pass
               repeat (NB * CPB) @(negedge clk);
            end else begin
               e = exp_q.pop_front();
               f = '1;
               f[0]   = 1'b0;
               f[8:1] = e[7:0];
`ifdef BF_UART_PARITY_EN
               f[9] = e[8];
`endif
               errs = 0;
               got = '0;
               got_par = 1'b0;
               for (int b = 0; b < NB; b++) begin
                  for (int c = 0; c < CPB; c++) begin
                     if (!(b == 0 && c == 0)) @(negedge clk);
                     if (tx !== f[b]) errs++;
                     if (c == 1 && b >= 1 && b <= 8) got[b-1] = tx;
                     if (c == 1 && b == 9) got_par = tx;
                  end
               end
               $display("tx frame %02h parity %0d (expected %02h) bit errors %0d", got, got_par, e[7:0], errs);
               check(errs == 0 && got == e[7:0], "frame", {got_par, 8'(errs), got}, {e[8], 8'h00, e[7:0]});
            end
            mon_busy = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Power-on reset
      #3 reset = 1'b0;
      repeat (3) @(negedge clk);
      check(tx == 1'b1,       "por_tx",       32'(tx),       32'h1);
      check(cpu_en == 1'b1,   "por_cpu_en",   32'(cpu_en),   32'h1);
      check(overflow == 1'b0, "por_overflow", 32'(overflow), 32'h0);
      check(tx_busy == 1'b0,  "por_tx_busy",  32'(tx_busy),  32'h0);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      mon_en = 1'b1;

      // Single 'A' (0x41, two ones -> parity 0): latency and busy
      exp_q.push_back({1'b0, 8'h41});
      stdout = 8'h41;
      stdout_en = 1'b1;
      @(negedge clk);                 // push edge N passed
      stdout_en = 1'b0;
      check(tx == 1'b1, "lat_n", 32'(tx), 32'h1);
      @(negedge clk);                 // after N+1 (pop)
      check(tx == 1'b1, "lat_n1", 32'(tx), 32'h1);
      @(negedge clk);                 // after N+2
      check(tx == 1'b0, "lat_n2", 32'(tx), 32'h0);
      check(tx_busy == 1'b1, "busy_mid", 32'(tx_busy), 32'h1);
      drain("drain_A");
      check(tx_busy == 1'b0, "busy_after", 32'(tx_busy), 32'h0);

      // Held strobe: 0x55 (four ones -> parity 0) pushes exactly once
      exp_q.push_back({1'b0, 8'h55});
      stdout = 8'h55;
      stdout_en = 1'b1;
      repeat (20) @(negedge clk);
      stdout_en = 1'b0;
      drain("drain_held");

      // Back-pressure: the first byte leaves for the shifter right away, so
      // the FIFO reaches 3 entries only on the fourth push.
      send_pulse(8'h48, 1'b0, 1'b1); repeat (4) @(negedge clk);   // 'H'
      send_pulse(8'h69, 1'b0, 1'b1); repeat (4) @(negedge clk);   // 'i'
      send_pulse(8'h21, 1'b0, 1'b1); repeat (4) @(negedge clk);   // '!'
      check(cpu_en == 1'b1, "cpu_en_before", 32'(cpu_en), 32'h1);
      exp_q.push_back({1'b0, 8'h0A});
      stdout = 8'h0A;
      stdout_en = 1'b1;
      @(negedge clk);                 // push edge: count becomes 3
      stdout_en = 1'b0;
      check(cpu_en == 1'b1, "cpu_en_same_cycle", 32'(cpu_en), 32'h1);
      @(negedge clk);                 // one edge later the stall is visible
      check(cpu_en == 1'b0, "cpu_en_fall", 32'(cpu_en), 32'h0);
      begin
         bit back = 1'b0;
         for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (cpu_en) begin
               back = 1'b1;
               break;
            end
         end
         check(back, "cpu_en_return", 32'(cpu_en), 32'h1);
      end
      drain("drain_backpressure");

      // Overflow: one in shifter + 4 in FIFO, the sixth push is dropped
      check(overflow == 1'b0, "ovf_before", 32'(overflow), 32'h0);
      send_pulse(8'h30, 1'b0, 1'b1);
      send_pulse(8'h31, 1'b1, 1'b1);
      send_pulse(8'h32, 1'b1, 1'b1);
      send_pulse(8'h33, 1'b0, 1'b1);
      send_pulse(8'h34, 1'b1, 1'b1);
      check(overflow == 1'b0, "ovf_at_full", 32'(overflow), 32'h0);
      send_pulse(8'h35, 1'b0, 1'b0);
      check(overflow == 1'b1, "ovf_set", 32'(overflow), 32'h1);
      drain("drain_overflow");
      check(overflow == 1'b1, "ovf_sticky", 32'(overflow), 32'h1);

      // Reset in the middle of a frame
      mon_en = 1'b0;
      send_pulse(8'h41, 1'b0, 1'b0);
      repeat (8) @(negedge clk);
      check(tx == 1'b0 || tx_busy == 1'b1, "pre_reset_busy", 32'(tx_busy), 32'h1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check(tx == 1'b1,       "rst_tx",       32'(tx),       32'h1);
      check(cpu_en == 1'b1,   "rst_cpu_en",   32'(cpu_en),   32'h1);
      check(overflow == 1'b0, "rst_overflow", 32'(overflow), 32'h0);
      check(tx_busy == 1'b0,  "rst_tx_busy",  32'(tx_busy),  32'h0);
      @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);
      check(tx == 1'b1 && tx_busy == 1'b0, "post_reset_idle", {31'd0, tx_busy}, 32'h0);
      mon_en = 1'b1;

      // Parity vectors: 0x07 -> 1, 0x03 -> 0
      send_pulse(8'h07, 1'b1, 1'b1);
      drain("drain_par07");
      send_pulse(8'h03, 1'b0, 1'b1);
      drain("drain_par03");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
